// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad one row at a time. It synchronizes and
//   debounces the column returns, then emits one strobe per physical press
//   with a 4-bit hex key code. Only one key is tracked at a time; other keys
//   are ignored while it is down.
//
// Parameters
//   SCAN_DIV    clock cycles per row slot (>= 4)
//   DB_CYCLES   consecutive stable cycles that confirm a press or release (>= 2)
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   col_i        raw column returns, asynchronous, active-low
//   row_o        one-hot active-high row drive
//   key_valid_o  one-cycle strobe per confirmed press
//   key_code_o   code of the last confirmed key, held until the next strobe
//   key_held_o   high while a confirmed key is down, including release debounce
module keypad_scanner #(
    parameter int SCAN_DIV  = 6000,
    parameter int DB_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_i,
    output logic [3:0] row_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic       key_held_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DB_CYCLES);

    typedef enum logic [1:0] {SCAN, PRESS, HELD, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       col_meta, col_s;
    logic [DIV_W-1:0] div;
    logic [DB_W-1:0]  db;
    logic [1:0]       r, c;
    logic [1:0]       row_idx, low_idx;
    logic             tick, any_low, line;
    logic             latch, db_clr, db_inc;
    logic [3:0]       row_nxt, code_nxt;
    logic             valid_nxt, held_nxt;

    assign tick    = (state == SCAN) && (div == DIV_LAST);
    assign any_low = ~&col_s;
    assign line    = col_s[c];

    always_comb begin
        row_idx = 2'd0;
        if (row_o[1]) row_idx = 2'd1;
        if (row_o[2]) row_idx = 2'd2;
        if (row_o[3]) row_idx = 2'd3;
    end

    // Lowest-index active column wins when several are pulled low.
    always_comb begin
        low_idx = 2'd0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!col_s[i-1]) low_idx = 2'(i - 1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        db_clr    = 1'b0;
        db_inc    = 1'b0;
        case (state)
            SCAN: begin
                if (tick && any_low) begin
                    state_nxt = PRESS;
                    latch     = 1'b1;
                    db_clr    = 1'b1;
                end
            end
            PRESS: begin
                if (line) begin
                    state_nxt = SCAN;
                end else begin
                    db_inc = 1'b1;
                    if (db == DB_LAST) state_nxt = HELD;
                end
            end
            HELD: begin
                if (line) begin
                    state_nxt = RELEASE;
                    db_clr    = 1'b1;
                end
            end
            RELEASE: begin
                if (!line) begin
                    state_nxt = HELD;
                end else begin
                    db_inc = 1'b1;
                    if (db == DB_LAST) state_nxt = SCAN;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // Output logic: computes the next value of every registered output.
    // The row advances both on an empty tick and on any return to SCAN.
    always_comb begin
        row_nxt   = row_o;
        code_nxt  = key_code_o;
        valid_nxt = 1'b0;
        if ((tick && !any_low) || (state != SCAN && state_nxt == SCAN)) begin
            row_nxt = {row_o[2:0], row_o[3]};
        end
        if (state == PRESS && state_nxt == HELD) begin
            valid_nxt = 1'b1;
            case ({r, c})
                4'h0: code_nxt = 4'h1;
                4'h1: code_nxt = 4'h2;
                4'h2: code_nxt = 4'h3;
                4'h3: code_nxt = 4'hA;
                4'h4: code_nxt = 4'h4;
                4'h5: code_nxt = 4'h5;
                4'h6: code_nxt = 4'h6;
                4'h7: code_nxt = 4'hB;
                4'h8: code_nxt = 4'h7;
                4'h9: code_nxt = 4'h8;
                4'hA: code_nxt = 4'h9;
                4'hB: code_nxt = 4'hC;
                4'hC: code_nxt = 4'hE;
                4'hD: code_nxt = 4'h0;
                4'hE: code_nxt = 4'hF;
                default: code_nxt = 4'hD;
            endcase
        end
        held_nxt = (state_nxt == HELD) || (state_nxt == RELEASE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= SCAN;
        else     state <= state_nxt;
    end

    // Datapath and output registers. div only runs in SCAN, so it is
    // already 0 whenever scanning resumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta    <= '1;
            col_s       <= '1;
            div         <= '0;
            db          <= '0;
            r           <= '0;
            c           <= '0;
            row_o       <= 4'b0001;
            key_valid_o <= 1'b0;
            key_code_o  <= '0;
            key_held_o  <= 1'b0;
        end else begin
            col_meta <= col_i;
            col_s    <= col_meta;
            if (state == SCAN && !tick) div <= div + 1'b1;
            else                        div <= '0;
            if (db_clr)                      db <= '0;
            else if (db_inc && db != DB_MAX) db <= db + 1'b1;
            if (latch) begin
                r <= row_idx;
                c <= low_idx;
            end
            row_o       <= row_nxt;
            key_valid_o <= valid_nxt;
            key_code_o  <= code_nxt;
            key_held_o  <= held_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner at SCAN_DIV=8, DB_CYCLES=5. A physical keypad
//   model turns a 16-bit pressed-key mask into column returns for the row
//   currently driven. A behavioural reference model predicts every output
//   each cycle. Directed scenarios and random presses with bounce follow.
module tb_keypad_scanner;

    localparam int SD  = 8;
    localparam int DBC = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_i = 4'hF;
    logic [3:0] row_o;
    logic       key_valid_o;
    logic [3:0] key_code_o;
    logic       key_held_o;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DB_CYCLES(DBC)) dut (
        .clk(clk),
        .rst(rst),
        .col_i(col_i),
        .row_o(row_o),
        .key_valid_o(key_valid_o),
        .key_code_o(key_code_o),
        .key_held_o(key_held_o)
    );

    int total   = 0;
    int bad     = 0;
    int strobes = 0;
    logic [15:0] keys = '0;   // bit r*4+c set = key at row r, column c is down

    // Code printed on the keypad, indexed by r*4+c.
    int code_map [0:15] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // Reference model (mode 0 idle scan, 1 confirming, 2 down, 3 confirming release).
    int         m_mode = 0;
    int         m_row  = 0;
    int         m_col  = 0;
    int         m_div  = 0;
    int         m_db   = 0;
    logic [3:0] m_s1   = 4'hF;
    logic [3:0] m_cs   = 4'hF;
    logic [3:0] m_code = 4'h0;
    logic       m_valid = 1'b0;

    task automatic model_step(input logic [3:0] cin, input logic rin);
        logic ln;
        if (rin) begin
            m_mode = 0; m_row = 0; m_col = 0; m_div = 0; m_db = 0;
            m_s1 = 4'hF; m_cs = 4'hF; m_code = 4'h0; m_valid = 1'b0;
            return;
        end
        m_valid = 1'b0;
        ln = m_cs[m_col];
        case (m_mode)
            0: begin
                if (m_div == SD - 1) begin
                    m_div = 0;
                    if (m_cs != 4'hF) begin
                        for (int k = 3; k >= 0; k--) if (!m_cs[k]) m_col = k;
                        m_db = 0;
                        m_mode = 1;
                    end else begin
                        m_row = (m_row + 1) % 4;
                    end
                end else begin
                    m_div++;
                end
            end
            1: begin
                if (ln) begin
                    m_mode = 0;
                    m_row = (m_row + 1) % 4;
                end else begin
                    m_db++;
                    if (m_db == DBC) begin
                        m_mode = 2;
                        m_valid = 1'b1;
                        m_code = 4'(code_map[m_row*4 + m_col]);
                    end
                end
            end
            2: begin
                if (ln) begin
                    m_db = 0;
                    m_mode = 3;
                end
            end
            default: begin
                if (!ln) begin
                    m_mode = 2;
                end else begin
                    m_db++;
                    if (m_db == DBC) begin
                        m_mode = 0;
                        m_row = (m_row + 1) % 4;
                    end
                end
            end
        endcase
        m_cs = m_s1;
        m_s1 = cin;
    endtask

    function automatic logic [3:0] drive(input logic [15:0] k, input logic [3:0] row);
        logic [3:0] v;
        v = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            if (row == 4'(1 << rr)) begin
                for (int cc = 0; cc < 4; cc++) if (k[rr*4 + cc]) v[cc] = 1'b0;
            end
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_keys(input logic [15:0] k);
        keys  = k;
        col_i = drive(keys, row_o);
    endtask

    task automatic cycle();
        logic [3:0] cin;
        logic       rin;
        cin = col_i;
        rin = rst;
        @(posedge clk);
        model_step(cin, rin);
        #1;
        chk("row", row_o, 4'(1 << m_row));
        chk("valid", 4'(key_valid_o), 4'(m_valid));
        chk("code", key_code_o, m_code);
        chk("held", 4'(key_held_o), 4'(m_mode == 2 || m_mode == 3));
        if (key_valid_o) strobes++;
        col_i = drive(keys, row_o);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_row(input logic [3:0] want, input int budget, input string tag);
        int n;
        n = 0;
        while (row_o !== want && n < budget) begin cycle(); n++; end
        chk(tag, row_o, want);
    endtask

    task automatic wait_held(input logic want, input int budget, input string tag);
        int n;
        n = 0;
        while (key_held_o !== want && n < budget) begin cycle(); n++; end
        chk(tag, 4'(key_held_o), 4'(want));
    endtask

    initial begin
        int s0;
        int n;
        logic [15:0] kk;

        // Reset and idle scan
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        chk("rst_row", row_o, 4'b0001);
        chk("rst_valid", 4'(key_valid_o), 4'h0);
        chk("rst_code", key_code_o, 4'h0);
        chk("rst_held", 4'(key_held_o), 4'h0);
        for (int i = 1; i <= 33; i++) begin
            cycle();
            chk("idle_row", row_o, 4'(1 << ((i / SD) % 4)));
            chk("idle_valid", 4'(key_valid_o), 4'h0);
        end

        // Single press "5" (row 1, column 1)
        wait_row(4'b0010, 40, "wait_row1");
        set_keys(16'h0020);
        run(50);
        set_keys(16'h0000);
        wait_held(1'b0, 40, "five_release");
        chk("five_strobes", 4'(strobes), 4'd1);
        chk("five_code", key_code_o, 4'h5);
        chk("five_resume", row_o, 4'b0100);

        // Press bounce on row 3 column 0, seen by the tick then lost
        n = 0;
        while (!(m_mode == 0 && m_row == 3 && m_div == SD - 4) && n < 60) begin cycle(); n++; end
        chk("bounce_sync", 4'(n >= 60), 4'h0);
        s0 = strobes;
        set_keys(16'h1000);
        run(2);
        set_keys(16'h0000);
        wait_row(4'b0001, 30, "bounce_resume");
        run(4);
        chk("bounce_strobes", 4'(strobes - s0), 4'd0);
        chk("bounce_code", key_code_o, 4'h5);

        // Release bounce on "D" (row 3, column 3)
        s0 = strobes;
        set_keys(16'h8000);
        wait_held(1'b1, 80, "d_press");
        chk("d_code", key_code_o, 4'hD);
        for (int t = 0; t < 3; t++) begin
            set_keys(16'h0000);
            for (int j = 0; j < 2; j++) begin cycle(); chk("d_held_hi", 4'(key_held_o), 4'h1); end
            set_keys(16'h8000);
            for (int j = 0; j < 2; j++) begin cycle(); chk("d_held_lo", 4'(key_held_o), 4'h1); end
        end
        set_keys(16'h0000);
        wait_held(1'b0, 40, "d_release");
        chk("d_strobes", 4'(strobes - s0), 4'd1);
        chk("d_code_kept", key_code_o, 4'hD);

        // Multi-key: "1" and "3" together, then "9" while "1" is down
        s0 = strobes;
        set_keys(16'h0005);
        wait_held(1'b1, 80, "multi_press");
        chk("multi_code", key_code_o, 4'h1);
        set_keys(16'h0405);
        run(30);
        chk("multi_strobes", 4'(strobes - s0), 4'd1);
        chk("multi_code_kept", key_code_o, 4'h1);
        set_keys(16'h0000);
        wait_held(1'b0, 40, "multi_release");

        // Mid-PRESS reset while "0" (row 3, column 1) is being confirmed
        s0 = strobes;
        set_keys(16'h2000);
        n = 0;
        while (!(m_mode == 1 && m_db == 3) && n < 80) begin cycle(); n++; end
        chk("press_db3_reached", 4'(n >= 80), 4'h0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_row", row_o, 4'b0001);
        chk("mid_rst_valid", 4'(key_valid_o), 4'h0);
        chk("mid_rst_code", key_code_o, 4'h0);
        chk("mid_rst_held", 4'(key_held_o), 4'h0);
        chk("mid_rst_strobes", 4'(strobes - s0), 4'd0);
        wait_held(1'b1, 80, "zero_press");
        chk("zero_code", key_code_o, 4'h0);
        chk("zero_strobes", 4'(strobes - s0), 4'd1);
        set_keys(16'h0000);
        wait_held(1'b0, 40, "zero_release");

        // Random presses with occasional bounce and second keys
        for (int it = 0; it < 25; it++) begin
            kk = 16'(1) << $urandom_range(15, 0);
            if ($urandom_range(3, 0) == 0) kk = kk | (16'(1) << $urandom_range(15, 0));
            n = int'($urandom_range(40, 1));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(9, 0) == 0) set_keys(16'h0000);
                else                           set_keys(kk);
                cycle();
            end
            set_keys(16'h0000);
            run(int'($urandom_range(30, 0)));
        end
        wait_held(1'b0, 40, "rand_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
